// File: rtl/control_config_hora_pkg.sv
// Shared encodings and default timing for the time-setting front end.
// Default timing constants assume a 100 MHz clk.
package control_config_hora_pkg;

  typedef logic [1:0] field_t;

  localparam field_t FIELD_NONE = 2'd0;
  localparam field_t FIELD_SS   = 2'd1;
  localparam field_t FIELD_MM   = 2'd2;
  localparam field_t FIELD_HH   = 2'd3;

  // State codes equal the field codes, so field_sel is the state register.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CFG_SS = 2'd1;
  localparam logic [1:0] ST_CFG_MM = 2'd2;
  localparam logic [1:0] ST_CFG_HH = 2'd3;

  localparam int DEF_HOLD_CYCLES    = 50_000_000;
  localparam int DEF_REPEAT_CYCLES  = 10_000_000;
  localparam int DEF_TIMEOUT_CYCLES = 1_000_000_000;
  localparam int DEF_BLINK_CYCLES   = 25_000_000;

  function automatic logic [2:0] field_onehot(input field_t f);
    case (f)
      FIELD_SS: field_onehot = 3'b001;
      FIELD_MM: field_onehot = 3'b010;
      FIELD_HH: field_onehot = 3'b100;
      default:  field_onehot = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/control_config_hora_detector_flanco_repeticion.sv
// Rising-edge detector with hold-then-repeat auto-repeat for one button.
// pulse is a same-cycle request; the top registers it onto en_up/en_down.
module detector_flanco_repeticion
  import control_config_hora_pkg::*;
#(
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  input  logic clear,
  output logic pulse
);

  localparam int CW_H = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int CW_R = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam int CW   = (CW_H > CW_R) ? CW_H : CW_R;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  logic          btn_q;
  logic          active;
  logic [CW-1:0] cnt;
  logic          rise;
  logic          fire;

  assign rise  = btn & ~btn_q;
  assign fire  = active & btn & (cnt == '0);
  assign pulse = ~clear & (rise | fire);

  // Down-counter reloads with the hold delay on a press, then the repeat period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_q  <= 1'b0;
      active <= 1'b0;
      cnt    <= '0;
    end else begin
      btn_q <= btn;
      if (clear || !btn) begin
        active <= 1'b0;
        cnt    <= '0;
      end else if (rise) begin
        active <= 1'b1;
        cnt    <= HOLD_LAST;
      end else if (fire) begin
        cnt <= REP_LAST;
      end else if (active) begin
        cnt <= cnt - CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/control_config_hora.sv
// Config-mode sequencer: field selection, up/down pulse routing, timeout and blink.
//   state     | meaning
//   IDLE      | normal clock display, buttons other than config ignored
//   CFG_SS    | adjusting seconds
//   CFG_MM    | adjusting minutes
//   CFG_HH    | adjusting hours
module control_config_hora
  import control_config_hora_pkg::*;
#(
  parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES  = DEF_REPEAT_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int BLINK_CYCLES   = DEF_BLINK_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_config,
  output logic [2:0] en_up,
  output logic [2:0] en_down,
  output logic [1:0] field_sel,
  output logic       config_mode,
  output logic       blink
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TO_ONE  = TW'(1);
  localparam logic [BW-1:0] BL_LAST = BW'(BLINK_CYCLES - 1);
  localparam logic [BW-1:0] BL_ONE  = BW'(1);

  logic [1:0]    state;
  logic [1:0]    state_nx;
  logic          up_q, down_q, left_q, right_q, config_q;
  logic          up_e, down_e, left_e, right_e, config_e;
  logic          cfg_act, lr_move, any_edge, issue, to_hit;
  logic          clear_up, clear_dn, up_req, dn_req;
  logic [TW-1:0] to_cnt;
  logic [BW-1:0] bl_cnt;

  assign up_e     = btn_up & ~up_q;
  assign down_e   = btn_down & ~down_q;
  assign left_e   = btn_left & ~left_q;
  assign right_e  = btn_right & ~right_q;
  assign config_e = btn_config & ~config_q;

  assign cfg_act  = (state != ST_IDLE);
  assign lr_move  = cfg_act & (left_e ^ right_e);
  assign any_edge = up_e | down_e | left_e | right_e | config_e;

  // Holding the opposite button blocks and cancels the repeat run.
  assign clear_up = ~cfg_act | config_e | lr_move | btn_down;
  assign clear_dn = ~cfg_act | config_e | lr_move | btn_up;

  detector_flanco_repeticion #(
    .HOLD_CYCLES  (HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_det_up (
    .clk  (clk),
    .reset(reset),
    .btn  (btn_up),
    .clear(clear_up),
    .pulse(up_req)
  );

  detector_flanco_repeticion #(
    .HOLD_CYCLES  (HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_det_dn (
    .clk  (clk),
    .reset(reset),
    .btn  (btn_down),
    .clear(clear_dn),
    .pulse(dn_req)
  );

  assign issue  = up_req | dn_req;
  assign to_hit = cfg_act & ~any_edge & ~issue & (to_cnt == TO_LAST);

  always_comb begin
    state_nx = state;
    if (config_e) begin
      state_nx = cfg_act ? ST_IDLE : ST_CFG_HH;
    end else if (lr_move) begin
      if (right_e) state_nx = (state == ST_CFG_SS) ? ST_CFG_HH : state - 2'd1;
      else         state_nx = (state == ST_CFG_HH) ? ST_CFG_SS : state + 2'd1;
    end else if (to_hit) begin
      state_nx = ST_IDLE;
    end
  end

  assign field_sel = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      up_q        <= 1'b0;
      down_q      <= 1'b0;
      left_q      <= 1'b0;
      right_q     <= 1'b0;
      config_q    <= 1'b0;
      en_up       <= 3'b000;
      en_down     <= 3'b000;
      config_mode <= 1'b0;
      to_cnt      <= '0;
    end else begin
      state       <= state_nx;
      up_q        <= btn_up;
      down_q      <= btn_down;
      left_q      <= btn_left;
      right_q     <= btn_right;
      config_q    <= btn_config;
      en_up       <= up_req ? field_onehot(state) : 3'b000;
      en_down     <= dn_req ? field_onehot(state) : 3'b000;
      config_mode <= (state_nx != ST_IDLE);
      if (state_nx == ST_IDLE || any_edge || issue) to_cnt <= '0;
      else                                          to_cnt <= to_cnt + TO_ONE;
    end
  end

  // Blink restarts high whenever a field is (re)entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink  <= 1'b0;
      bl_cnt <= '0;
    end else if (state_nx == ST_IDLE) begin
      blink  <= 1'b0;
      bl_cnt <= '0;
    end else if (state_nx != state) begin
      blink  <= 1'b1;
      bl_cnt <= '0;
    end else if (bl_cnt == BL_LAST) begin
      blink  <= ~blink;
      bl_cnt <= '0;
    end else begin
      bl_cnt <= bl_cnt + BL_ONE;
    end
  end

endmodule

// File: doc/control_config_hora.md
Name: control_config_hora

Overview:
- Sequencer for the time-setting front end: owns the shared up/down/left/right/config buttons and routes single-cycle increment/decrement pulses to one of three 2-digit counters (hours, minutes, seconds).
- Those counters are up/down counters with internal rising-edge detection and wrap (seconds/minutes 0..59).
- Sits between the debounced button block and the counter bank.
- Provides field-select, config-mode and blink outputs for the display driver.

Parameters:
- HOLD_CYCLES, 50_000_000: cycles an up/down button must stay held after the first pulse before auto-repeat starts.
- REPEAT_CYCLES, 10_000_000: auto-repeat period, in cycles. Minimum 2.
- TIMEOUT_CYCLES, 1_000_000_000: inactivity cycles in config mode before returning to IDLE.
- BLINK_CYCLES, 25_000_000: half-period of the blink output.

Ports:
- clk  in  1  system clock, single clock domain
- reset  in  1  asynchronous, active-low reset (0 = reset)
- btn_up  in  1  debounced level, synchronous to clk
- btn_down  in  1  debounced level
- btn_left  in  1  debounced level
- btn_right  in  1  debounced level
- btn_config  in  1  debounced level; toggles config mode
- en_up  out  3  per-field increment pulse: [0]=ss, [1]=mm, [2]=hh
- en_down  out  3  per-field decrement pulse, same indexing
- field_sel  out  2  0=none, 1=ss, 2=mm, 3=hh
- config_mode  out  1  high in any CFG state
- blink  out  1  blink gate for the selected field

Behaviour:
- Reset asserted (async): state=IDLE. All outputs 0. All counters and edge registers cleared.
- Edge detection: each button is registered once. edge = level & ~registered.
- All outputs are registered. A pulse appears the cycle after the input is first sampled high.

State machine (field_sel follows state):
- States: IDLE(0), CFG_SS(1), CFG_MM(2), CFG_HH(3).
- IDLE: config edge -> CFG_HH. Up/down/left/right are ignored and produce no pulses.
- CFG_x: config edge -> IDLE.
- CFG_x: right edge moves HH->MM->SS->HH.
- CFG_x: left edge moves HH->SS->MM->HH.
- Same-cycle priority: config > left/right > up/down.
- Left and right edges in the same cycle: both ignored.

Up/down pulses:
- Only in CFG states, and only on the bit indexed by field_sel-1.
- Each pulse is exactly 1 cycle wide, with at least 1 low cycle between pulses. This guarantees a rising edge at the counter for every pulse.
- Up and down rising in the same cycle: neither pulses. If both are held, repeat is suppressed.
- Auto-repeat sequence for a button held from cycle t:
  - first pulse at t+1;
  - if still held, next pulse at t+1+HOLD_CYCLES;
  - then one pulse every REPEAT_CYCLES.
  - Release clears the hold counter immediately.
- Field change, exit to IDLE, or the opposite button rising: the repeat counter is cleared. A new press is required.

Timeout:
- The counter runs only in CFG states.
- It is cleared by any button edge and by any issued up/down pulse.
- On reaching TIMEOUT_CYCLES-1 -> IDLE next cycle, and the counter clears.

Blink:
- 0 in IDLE.
- On entering CFG or changing field: forced to 1 and the phase counter restarts.
- Otherwise toggles every BLINK_CYCLES.

Counter widths: each is $clog2 of its parameter. No overflow beyond the terminal count; each counter saturates or clears as described above.

Reset mid-operation: any pulse in flight is dropped. en_up and en_down go to 0 asynchronously.

Decomposition:
- Shared package:
  - field encoding constants FIELD_NONE/SS/MM/HH (2 bits);
  - state encoding for IDLE/CFG_SS/CFG_MM/CFG_HH;
  - default timing constants for a 100 MHz clock.
- One sub-module, detector_flanco_repeticion: per-button edge detector plus hold/repeat counter.
  - Ports: clk, reset, btn, clear, pulse.
  - Instantiated twice (up, down).
- Left/right/config use plain edge registers in the top module.

Test Plan (HOLD=8, REPEAT=4, TIMEOUT=64, BLINK=4):
1. Press config, then reset=0 for 2 cycles, then reset=1 -> state IDLE, config_mode=0, field_sel=0, en_up=en_down=0, blink=0. Outputs are cleared while reset is low, with no clock edge required.
2. Config edge, then btn_up high 3 cycles -> field_sel=3, blink=1. en_up=3'b100 for exactly one cycle, one cycle after the up edge. No other pulses.
3. In CFG_MM, hold btn_down 20 cycles from t -> en_down=3'b010 pulses at t+1, t+9, t+13, t+17. No pulse after release.
4. From CFG_HH: right x3 -> field_sel 2, 1, 3. Left x1 -> field_sel 1. Left and right in the same cycle -> field_sel unchanged.
5. btn_up and btn_down rising in the same cycle in CFG_SS -> no pulses. btn_up in IDLE -> no pulses.
6. Enter config and apply no buttons -> config_mode drops 64 cycles after the config edge. Blink toggles every 4 cycles before that, and is 0 afterwards.
